// File: rtl/dmem_stream_reader.sv
// dmem_stream_reader
// Reads a contiguous word range from the data memory and streams it out over a
// valid/ready interface with a single output register stage. The range is
// validated up front with 33-bit arithmetic so a wrapping base never reads.
module dmem_stream_reader #(
    parameter int MEM_WORDS = 1024,
    parameter int LEN_W     = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [31:0]      base_addr,
    input  logic [LEN_W-1:0] length,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [31:0]      mem_addr,
    output logic             mem_we,
    output logic [31:0]      mem_wd,
    input  logic [31:0]      mem_rd,
    output logic             m_valid,
    output logic [31:0]      m_data,
    output logic             m_last,
    input  logic             m_ready
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } state_t;

    state_t            state, state_nxt;
    logic [31:0]       base_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  cnt_q;
    logic [32:0]       range_end;
    logic              range_bad;
    logic              accept;
    logic              load;
    logic              last_issue;

    // The reader never writes the memory.
    assign mem_we = 1'b0;
    assign mem_wd = 32'h0;

    // Range end is formed one bit wider than the address so 0xFFFFFFFF+1 is caught.
    assign range_end  = {1'b0, base_addr} + {{(33-LEN_W){1'b0}}, length};
    assign range_bad  = range_end > 33'(MEM_WORDS);
    assign accept     = (state == IDLE) && start;
    assign load       = (state == READ) && (!m_valid || m_ready);
    assign last_issue = (cnt_q == (len_q - LEN_W'(1)));

    // State register; reset aborts any transfer without a done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode plus the state-derived outputs busy, done and mem_addr.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        mem_addr  = 32'h0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (range_bad || (length == '0)) begin
                        state_nxt = FIN;
                    end else begin
                        state_nxt = READ;
                    end
                end
            end
            READ: begin
                busy     = 1'b1;
                mem_addr = base_q + 32'(cnt_q);
                if (load && last_issue) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (m_valid && m_ready && m_last) begin
                    state_nxt = FIN;
                end
            end
            FIN: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Command capture, issue counter and sticky error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q <= 32'h0;
            len_q  <= '0;
            cnt_q  <= '0;
            err    <= 1'b0;
        end else if (accept) begin
            base_q <= base_addr;
            len_q  <= length;
            cnt_q  <= '0;
            err    <= range_bad;
        end else if (load) begin
            cnt_q  <= cnt_q + LEN_W'(1);
        end
    end

    // Output register: refill whenever it is empty or being consumed, else hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_data  <= 32'h0;
            m_last  <= 1'b0;
        end else if (load) begin
            m_valid <= 1'b1;
            m_data  <= mem_rd;
            m_last  <= last_issue;
        end else if (m_valid && m_ready) begin
            m_valid <= 1'b0;
            m_last  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dmem_stream_reader.sv
// Testbench for dmem_stream_reader: table of directed transfers, a reset abort
// sequence, and randomized transfers against a queue-based reference model.
module tb_dmem_stream_reader;

    localparam int MEM_WORDS = 1024;
    localparam int LEN_W     = 11;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [31:0]      base_addr;
    logic [LEN_W-1:0] length;
    logic             busy;
    logic             done;
    logic             err;
    logic [31:0]      mem_addr;
    logic             mem_we;
    logic [31:0]      mem_wd;
    logic [31:0]      mem_rd;
    logic             m_valid;
    logic [31:0]      m_data;
    logic             m_last;
    logic             m_ready;

    logic [31:0] mem [MEM_WORDS];

    int n_tests = 0;
    int n_fail  = 0;

    dmem_stream_reader #(.MEM_WORDS(MEM_WORDS), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .length(length), .busy(busy), .done(done), .err(err),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wd(mem_wd), .mem_rd(mem_rd),
        .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational memory read port
    assign mem_rd = (mem_addr < 32'(MEM_WORDS)) ? mem[mem_addr[9:0]] : 32'h0;

    typedef struct {
        logic [31:0] base;
        int          len;
        int          mode;      // 0: ready high, 1: 1,0,0,1,0,1 pattern, 2: random
        bit          poke;      // pulse start while busy
        bit          exp_err;
        int          exp_beats;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Runs one transfer and checks it against an expected word list built from mem.
    task automatic run_xfer(input logic [31:0] b, input int len, input int mode,
                            input bit poke, input bit exp_err, input int exp_beats);
        logic [31:0] expq[$];
        logic [31:0] w;
        int  hs, last_hs, budget, stall_bad, busy_bad;
        bit  got_done, pv, pr, rdy, normal;
        logic [31:0] pd;
        logic pl;
        normal = !exp_err && (len > 0);
        if (normal) begin
            for (int i = 0; i < len; i++) expq.push_back(mem[b + 32'(i)]);
        end
        budget = 6 * len + 20;
        hs = 0; last_hs = 0; stall_bad = 0; busy_bad = 0;
        got_done = 0; pv = 0; pr = 0; pd = '0; pl = 0;
        @(negedge clk);
        start = 1'b1; base_addr = b; length = len[LEN_W-1:0]; m_ready = 1'b0;
        for (int cyc = 1; cyc <= budget; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (poke && cyc >= 2 && cyc <= 4) begin
                start = 1'b1; base_addr = 32'd0; length = 11'd5;
            end
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (((cyc - 1) % 6) == 0) || (((cyc - 1) % 6) == 3) || (((cyc - 1) % 6) == 5);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            m_ready = rdy;
            if (cyc == 1) begin
                check("cyc1_busy", busy, normal);
                check("cyc1_err", err, exp_err);
                if (normal) check("cyc1_mem_addr", mem_addr, b);
            end
            if (pv && !pr && !(m_valid && m_data == pd && m_last == pl)) stall_bad++;
            if (done) begin
                got_done = 1;
                check("done_cycle", cyc, normal ? last_hs + 1 : 1);
                check("done_err", err, exp_err);
                check("done_m_valid", m_valid, 0);
                check("done_busy", busy, 0);
                break;
            end
            if (busy !== normal) busy_bad++;
            if (m_valid && rdy) begin
                if (expq.size() == 0) begin
                    check("extra_beat", 1, 0);
                end else begin
                    w = expq.pop_front();
                    check("beat_data", m_data, w);
                    check("beat_last", m_last, expq.size() == 0);
                end
                if (mode == 0) check("beat_cycle", cyc, hs + 2);
                hs++;
                last_hs = cyc;
            end
            pv = m_valid; pr = rdy; pd = m_data; pl = m_last;
        end
        start = 1'b0;
        if (!got_done) check("timeout_no_done", 0, 1);
        check("beat_count", hs, exp_beats);
        check("stall_violations", stall_bad, 0);
        check("busy_violations", busy_bad, 0);
        check("mem_we", {mem_we, mem_wd}, 0);
        @(negedge clk);
        check("post_done_low", {done, busy, m_valid}, 0);
        check("err_sticky", err, exp_err);
    endtask

    vec_t vecs[10];

    initial begin
        logic [31:0] rb;
        int rl;
        bit re;
        start = 1'b0; base_addr = '0; length = '0; m_ready = 1'b0;
        for (int i = 0; i < MEM_WORDS; i++) mem[i] = 32'hA000_0000 + 32'(i);

        vecs[0] = '{32'd10,         4,    0, 1'b0, 1'b0, 4};
        vecs[1] = '{32'd10,         4,    1, 1'b0, 1'b0, 4};
        vecs[2] = '{32'd1020,       4,    0, 1'b0, 1'b0, 4};
        vecs[3] = '{32'd1021,       4,    0, 1'b0, 1'b1, 0};
        vecs[4] = '{32'd10,         4,    0, 1'b1, 1'b0, 4};
        vecs[5] = '{32'd5,          0,    0, 1'b0, 1'b0, 0};
        vecs[6] = '{32'd1023,       1,    1, 1'b0, 1'b0, 1};
        vecs[7] = '{32'hFFFF_FFFF,  1,    0, 1'b0, 1'b1, 0};
        vecs[8] = '{32'd0,          1024, 2, 1'b0, 1'b0, 1024};
        vecs[9] = '{32'd1,          1024, 0, 1'b0, 1'b1, 0};

        rst_n = 1'b0;
        #3;
        check("reset_outputs", {busy, done, err, m_valid, m_last, m_data, mem_addr}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int v = 0; v < 10; v++) begin
            run_xfer(vecs[v].base, vecs[v].len, vecs[v].mode, vecs[v].poke,
                     vecs[v].exp_err, vecs[v].exp_beats);
        end

        // Error start directly followed by a valid one
        run_xfer(32'd1021, 4, 0, 1'b0, 1'b1, 0);
        run_xfer(32'd10, 4, 2, 1'b0, 1'b0, 4);

        // Reset in the middle of a 16-word transfer
        @(negedge clk);
        start = 1'b1; base_addr = 32'd100; length = 11'd16; m_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        check("pre_reset_valid", {busy, m_valid}, 2'b11);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_outputs", {busy, done, err, m_valid, m_last, m_data, mem_addr}, 0);
        begin
            int dseen = 0;
            repeat (3) begin
                @(negedge clk);
                if (done) dseen++;
            end
            check("no_done_after_reset", dseen, 0);
        end
        rst_n = 1'b1;
        run_xfer(32'd100, 16, 0, 1'b0, 1'b0, 16);

        // Randomized transfers against the reference model
        for (int i = 0; i < MEM_WORDS; i++) mem[i] = $urandom;
        for (int t = 0; t < 14; t++) begin
            if ($urandom_range(0, 2) == 0) rb = 32'($urandom_range(990, 1030));
            else                           rb = 32'($urandom_range(0, 900));
            rl = $urandom_range(0, 48);
            re = (longint'(rb) + longint'(rl)) > longint'(MEM_WORDS);
            run_xfer(rb, rl, 2, 1'($urandom_range(0, 1)) && (rl >= 8) && !re, re, re ? 0 : rl);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
